// File: rtl/core_pkg.sv
// Shared core definitions: writeback source encoding and register address width.
package core_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_LOAD,
        WB_PIM,
        WB_EX
    } wb_src_e;

endpackage

// File: rtl/wb_rd_fifo.sv
// In-order FIFO of outstanding load destination registers.
module wb_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/wb_scoreboard.sv
// Writeback arbiter (load > PIM > EX) and pending-register scoreboard.
// Optional PIM path enabled by defining WB_SCOREBOARD_PIM_EN.
module wb_scoreboard
    import core_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_reg_write_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [31:0]           ex_data_i,
    output logic                  ex_ready_o,
    input  logic                  ld_issue_i,
    input  logic [REG_ADDR_W-1:0] ld_rd_i,
    output logic                  ld_ready_o,
    input  logic                  ld_rvalid_i,
    input  logic [31:0]           ld_rdata_i,
    input  logic                  pim_issue_i,
    input  logic [REG_ADDR_W-1:0] pim_rd_i,
    input  logic                  pim_done_i,
    input  logic [31:0]           pim_result_i,
    output logic                  pim_ack_o,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    input  logic                  dec_uses_rs1_i,
    input  logic                  dec_uses_rs2_i,
    input  logic                  dec_writes_rd_i,
    output logic                  stall_o,
    output logic                  wb_reg_write_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [31:0]           wb_data_o,
    output logic                  err_o
);
    logic [31:0]           pend_q, pend_d, set_v, clr_v;
    logic                  wb_we_q, wb_we_d, err_q, err_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d, fifo_head, pim_rd_q;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  fifo_full, fifo_empty, ld_push, ld_pop;
    wb_src_e               src;

    assign ld_ready_o = !fifo_full;
    assign ld_push    = ld_issue_i && !fifo_full;
    assign ld_pop     = ld_rvalid_i && !fifo_empty;

    wb_rd_fifo #(.DEPTH(LD_DEPTH), .W(REG_ADDR_W)) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ld_push),
        .pop_i   (ld_pop),
        .din_i   (ld_rd_i),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef WB_SCOREBOARD_PIM_EN
    assign pim_ack_o  = pim_done_i && !ld_rvalid_i;
    assign ex_ready_o = !ld_rvalid_i && !pim_done_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)            pim_rd_q <= '0;
        else if (pim_issue_i) pim_rd_q <= pim_rd_i;
    end
`else
    logic unused_pim;
    assign unused_pim = ^{pim_issue_i, pim_rd_i, pim_done_i};
    assign pim_ack_o  = 1'b0;
    assign ex_ready_o = !ld_rvalid_i;
    assign pim_rd_q   = '0;
`endif

    // A load response always claims the port, even one dropped on an empty FIFO.
    always_comb begin
        src = WB_NONE;
        if (ld_rvalid_i)    src = fifo_empty ? WB_NONE : WB_LOAD;
        else if (pim_ack_o) src = WB_PIM;
        else if (ex_valid_i) src = WB_EX;
    end

    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        clr_v     = '0;
        set_v     = '0;
        case (src)
            WB_LOAD: begin
                wb_we_d          = 1'b1;
                wb_rd_d          = fifo_head;
                wb_data_d        = ld_rdata_i;
                clr_v[fifo_head] = 1'b1;
            end
            WB_PIM: begin
                wb_we_d         = 1'b1;
                wb_rd_d         = pim_rd_q;
                wb_data_d       = pim_result_i;
                clr_v[pim_rd_q] = 1'b1;
            end
            WB_EX: begin
                wb_we_d   = ex_reg_write_i;
                wb_rd_d   = ex_rd_i;
                wb_data_d = ex_data_i;
            end
            default: ;
        endcase
        if (wb_rd_d == '0) wb_we_d = 1'b0;

        if (ld_push) set_v[ld_rd_i] = 1'b1;
`ifdef WB_SCOREBOARD_PIM_EN
        if (pim_issue_i) set_v[pim_rd_i] = 1'b1;
`endif
        set_v[0] = 1'b0;
        pend_d   = (pend_q & ~clr_v) | set_v;
        err_d    = err_q | (ld_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign stall_o = (dec_uses_rs1_i  && pend_q[dec_rs1_i]) ||
                     (dec_uses_rs2_i  && pend_q[dec_rs2_i]) ||
                     (dec_writes_rd_i && pend_q[dec_rd_i]);

    assign wb_reg_write_o = wb_we_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign err_o          = err_q;
endmodule
